// File: rtl/sal_axi_aw_b_apb_master.sv
// Host-side bus master front-end: AXI write-address master, B-channel capture buffer with
// outstanding tracking, and an APB master for controller register programming.
module sal_axi_aw_b_apb_master #(
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned APB_ADDR_WIDTH  = 32,
  parameter int unsigned APB_DATA_WIDTH  = 32,
  parameter int unsigned MAX_OUTSTANDING = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // host address command
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ID_WIDTH-1:0]       cmd_id,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [7:0]                cmd_len,
  input  logic [2:0]                cmd_size,
  input  logic [1:0]                cmd_burst,
  // AXI address channel
  output logic                      avalid,
  input  logic                      aready,
  output logic [ID_WIDTH-1:0]       aid,
  output logic [ADDR_WIDTH-1:0]     aaddr,
  output logic [7:0]                alen,
  output logic [2:0]                asize,
  output logic [1:0]                aburst,
  // AXI write response channel
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [ID_WIDTH-1:0]       bid,
  input  logic [1:0]                bresp,
  // captured response to host
  output logic                      brsp_valid,
  input  logic                      brsp_ready,
  output logic [ID_WIDTH-1:0]       brsp_id,
  output logic [1:0]                brsp_resp,
  output logic [7:0]                outstanding,
  // host APB request
  input  logic                      apb_req_valid,
  output logic                      apb_req_ready,
  input  logic                      apb_req_write,
  input  logic [APB_ADDR_WIDTH-1:0] apb_req_addr,
  input  logic [APB_DATA_WIDTH-1:0] apb_req_wdata,
  output logic                      apb_rsp_valid,
  output logic [APB_DATA_WIDTH-1:0] apb_rsp_rdata,
  output logic                      apb_rsp_err,
  // APB bus
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic                      pready,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pslverr
);

  localparam logic [7:0] MaxOut = 8'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} apb_state_e;

  apb_state_e state_q;
  logic       a_hs;
  logic       b_hs;
  logic       b_dec;

  // Ready outputs are held low while reset is asserted so nothing handshakes during reset.
  assign cmd_ready     = rst_n && (!avalid || aready) && (outstanding < MaxOut);
  assign bready        = rst_n && (!brsp_valid || brsp_ready);
  assign apb_req_ready = rst_n && (state_q == StIdle);

  assign a_hs  = avalid && aready;
  assign b_hs  = bvalid && bready;
  assign b_dec = b_hs && (outstanding != 8'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      avalid <= 1'b0;
      aid    <= '0;
      aaddr  <= '0;
      alen   <= '0;
      asize  <= '0;
      aburst <= '0;
    end else if (cmd_valid && cmd_ready) begin
      avalid <= 1'b1;
      aid    <= cmd_id;
      aaddr  <= cmd_addr;
      alen   <= cmd_len;
      asize  <= cmd_size;
      aburst <= cmd_burst;
    end else if (aready) begin
      avalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      brsp_valid <= 1'b0;
      brsp_id    <= '0;
      brsp_resp  <= '0;
    end else if (b_hs) begin
      brsp_valid <= 1'b1;
      brsp_id    <= bid;
      brsp_resp  <= bresp;
    end else if (brsp_ready) begin
      brsp_valid <= 1'b0;
    end
  end

  // A B handshake with nothing outstanding is dropped rather than wrapping the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding <= 8'd0;
    end else if (a_hs && !b_dec) begin
      outstanding <= outstanding + 8'd1;
    end else if (!a_hs && b_dec) begin
      outstanding <= outstanding - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      psel          <= 1'b0;
      penable       <= 1'b0;
      pwrite        <= 1'b0;
      paddr         <= '0;
      pwdata        <= '0;
      apb_rsp_valid <= 1'b0;
      apb_rsp_rdata <= '0;
      apb_rsp_err   <= 1'b0;
    end else begin
      apb_rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (apb_req_valid) begin
            pwrite  <= apb_req_write;
            paddr   <= apb_req_addr;
            pwdata  <= apb_req_wdata;
            psel    <= 1'b1;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          penable <= 1'b1;
          state_q <= StAccess;
        end
        StAccess: begin
          if (pready) begin
            psel          <= 1'b0;
            penable       <= 1'b0;
            apb_rsp_valid <= 1'b1;
            apb_rsp_err   <= pslverr;
            if (!pwrite) apb_rsp_rdata <= prdata;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sal_axi_aw_b_apb_master.sv
// Self-checking bench: directed AXI/B sequences, a table of APB transfers and a randomized
// AXI/B phase scored against a queue-based model of the channel rules.
module tb_sal_axi_aw_b_apb_master;

  localparam int unsigned Max = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        avalid, aready;
  logic [3:0]  aid;
  logic [31:0] aaddr;
  logic [7:0]  alen;
  logic [2:0]  asize;
  logic [1:0]  aburst;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        brsp_valid, brsp_ready;
  logic [3:0]  brsp_id;
  logic [1:0]  brsp_resp;
  logic [7:0]  outstanding;
  logic        apb_req_valid, apb_req_ready, apb_req_write;
  logic [31:0] apb_req_addr, apb_req_wdata;
  logic        apb_rsp_valid, apb_rsp_err;
  logic [31:0] apb_rsp_rdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;

  int checks = 0;
  int failures = 0;

  sal_axi_aw_b_apb_master #(.MAX_OUTSTANDING(Max)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .avalid(avalid), .aready(aready), .aid(aid), .aaddr(aaddr), .alen(alen), .asize(asize),
    .aburst(aburst),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .brsp_valid(brsp_valid), .brsp_ready(brsp_ready), .brsp_id(brsp_id),
    .brsp_resp(brsp_resp), .outstanding(outstanding),
    .apb_req_valid(apb_req_valid), .apb_req_ready(apb_req_ready),
    .apb_req_write(apb_req_write), .apb_req_addr(apb_req_addr),
    .apb_req_wdata(apb_req_wdata), .apb_rsp_valid(apb_rsp_valid),
    .apb_rsp_rdata(apb_rsp_rdata), .apb_rsp_err(apb_rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_in;
    logic        err_in;
    int          wait_cycles;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } apb_vec_t;

  apb_vec_t apb_tab[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apb_run(input apb_vec_t v);
    apb_req_valid = 1'b1;
    apb_req_write = v.write;
    apb_req_addr  = v.addr;
    apb_req_wdata = v.wdata;
    settle();
    check("apb_req_ready_idle", apb_req_ready, 1);
    tick();
    apb_req_valid = 1'b0;
    apb_req_addr  = 32'hFFFF_FFFF;
    apb_req_wdata = 32'hFFFF_FFFF;
    settle();
    check("apb_setup", {psel, penable, apb_req_ready}, 3'b100);
    tick();
    for (int k = 0; k <= v.wait_cycles; k++) begin
      pready  = (k == v.wait_cycles);
      prdata  = v.rdata_in;
      pslverr = v.err_in;
      settle();
      check("apb_access", {psel, penable, apb_req_ready, apb_rsp_valid}, 4'b1100);
      check("apb_hold_addr", paddr, v.addr);
      check("apb_hold_data", {pwrite, pwdata}, {v.write, v.wdata});
      tick();
    end
    pready  = 1'b0;
    prdata  = 32'h0BAD_0BAD;
    pslverr = 1'b0;
    settle();
    check("apb_rsp_pulse", {apb_rsp_valid, psel, penable}, 3'b100);
    check("apb_rsp_rdata", apb_rsp_rdata, v.exp_rdata);
    check("apb_rsp_err", apb_rsp_err, v.exp_err);
    tick();
    check("apb_rsp_one_cycle", apb_rsp_valid, 0);
  endtask

  // Reference model for the randomized phase: pending address command, captured B buffer,
  // and the number of address handshakes still awaiting a response.
  logic [48:0] aq[$];
  logic [5:0]  bq[$];
  int          cnt;

  task automatic random_phase(input int cycles);
    logic exp_av, exp_cr, exp_br, ahs, bhs, acc;
    aq.delete();
    bq.delete();
    cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      cmd_valid  = 1'($urandom_range(0, 1));
      cmd_id     = 4'($urandom);
      cmd_addr   = $urandom;
      cmd_len    = 8'($urandom);
      cmd_size   = 3'($urandom);
      cmd_burst  = 2'($urandom_range(0, 2));
      aready     = ($urandom_range(0, 3) != 0);
      bvalid     = (cnt > 0) && ($urandom_range(0, 2) != 0);
      bid        = 4'($urandom);
      bresp      = 2'($urandom);
      brsp_ready = 1'($urandom_range(0, 1));
      settle();
      exp_av = (aq.size() != 0);
      exp_cr = (!exp_av || aready) && (cnt < Max);
      exp_br = (bq.size() == 0) || brsp_ready;
      check("rnd_avalid", avalid, exp_av);
      if (exp_av) check("rnd_afields", {aid, aaddr, alen, asize, aburst}, aq[0]);
      check("rnd_cmd_ready", cmd_ready, exp_cr);
      check("rnd_bready", bready, exp_br);
      check("rnd_brsp_valid", brsp_valid, bq.size() != 0);
      if (bq.size() != 0) check("rnd_brsp", {brsp_id, brsp_resp}, bq[0]);
      check("rnd_outstanding", outstanding, 8'(cnt));
      ahs = exp_av && aready;
      acc = cmd_valid && exp_cr;
      bhs = bvalid && exp_br;
      if (ahs) void'(aq.pop_front());
      if (acc) aq.push_back({cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst});
      if (bq.size() != 0 && brsp_ready) void'(bq.pop_front());
      if (bhs) bq.push_back({bid, bresp});
      cnt = cnt + (ahs ? 1 : 0) - ((bhs && cnt > 0) ? 1 : 0);
      tick();
    end
  endtask

  initial begin
    apb_tab[0] = '{1'b1, 32'h10, 32'hA5A5_A5A5, 32'h0000_DEAD, 1'b0, 2, 32'h0, 1'b0};
    apb_tab[1] = '{1'b0, 32'h20, 32'h0,        32'h0000_1234, 1'b1, 0, 32'h1234, 1'b1};
    apb_tab[2] = '{1'b1, 32'h24, 32'h5,        32'h0000_FFFF, 1'b0, 1, 32'h1234, 1'b0};
    apb_tab[3] = '{1'b0, 32'h28, 32'h0,        32'hCAFE_F00D, 1'b0, 3, 32'hCAFE_F00D, 1'b0};

    // Reset with live inputs: reset must win.
    rst_n = 1'b0;
    cmd_valid = 1'b1; cmd_id = 4'h7; cmd_addr = 32'h55; cmd_len = 8'h3; cmd_size = 3'h2;
    cmd_burst = 2'h1; aready = 1'b1; bvalid = 1'b1; bid = 4'h1; bresp = 2'h1;
    brsp_ready = 1'b0; apb_req_valid = 1'b1; apb_req_write = 1'b1; apb_req_addr = 32'h8;
    apb_req_wdata = 32'h9; pready = 1'b1; prdata = 32'h77; pslverr = 1'b1;
    repeat (3) tick();
    check("rst_aw", {avalid, aid, aaddr, alen, asize, aburst}, 0);
    check("rst_b", {bready, brsp_valid, brsp_id, brsp_resp}, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_apb_ctl", {psel, penable, pwrite}, 0);
    check("rst_apb_bus", {paddr, pwdata}, 0);
    check("rst_apb_rsp", {apb_rsp_valid, apb_rsp_err, apb_rsp_rdata}, 0);

    rst_n = 1'b1;
    cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    aready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0; apb_req_valid = 1'b0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    settle();
    check("post_rst_ready", {cmd_ready, bready, apb_req_ready}, 3'b111);
    tick();

    // Two back-to-back commands with aready high.
    cmd_valid = 1'b1; aready = 1'b1;
    settle();
    check("b2b_cmd_ready", cmd_ready, 1);
    tick();
    cmd_addr = 32'h4;
    settle();
    check("b2b_first", {avalid, aaddr}, {1'b1, 32'h0});
    tick();
    cmd_valid = 1'b0;
    settle();
    check("b2b_second", {avalid, aaddr, outstanding}, {1'b1, 32'h4, 8'd1});
    tick();
    check("b2b_done", {avalid, outstanding}, {1'b0, 8'd2});

    // At the outstanding limit a new command stalls until a B handshake.
    cmd_valid = 1'b1; cmd_addr = 32'h8; aready = 1'b0;
    settle();
    check("max_stall", cmd_ready, 0);
    tick();
    check("max_stall_hold", {avalid, cmd_ready}, 2'b00);
    bvalid = 1'b1; bid = 4'd3; bresp = 2'd2; brsp_ready = 1'b0;
    settle();
    check("b_ready_empty", bready, 1);
    tick();
    bid = 4'd5; bresp = 2'd1;
    check("b_capture", {brsp_valid, brsp_id, brsp_resp}, {1'b1, 4'd3, 2'd2});
    check("b_full_bready", bready, 0);
    check("b_dec", outstanding, 1);
    check("max_release", cmd_ready, 1);
    tick();
    cmd_addr = 32'hC;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("stall_hold", {avalid, aaddr, cmd_ready}, {1'b1, 32'h8, 1'b0});
      check("stall_brsp", {brsp_id, outstanding}, {4'd3, 8'd1});
      tick();
    end
    aready = 1'b1;
    settle();
    check("stall_release", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; brsp_ready = 1'b1;
    settle();
    check("next_cmd", {avalid, aaddr, outstanding, bready}, {1'b1, 32'hC, 8'd2, 1'b1});
    tick();
    bvalid = 1'b0;
    check("both_hs", {avalid, outstanding}, {1'b0, 8'd2});
    check("b_pop_refill", {brsp_valid, brsp_id, brsp_resp}, {1'b1, 4'd5, 2'd1});
    tick();
    check("b_pop_empty", brsp_valid, 0);
    bvalid = 1'b1; bid = 4'd0; bresp = 2'd0;
    tick();
    tick();
    check("drain", outstanding, 0);
    tick();
    check("no_underflow", outstanding, 0);
    bvalid = 1'b0;
    tick();

    foreach (apb_tab[i]) apb_run(apb_tab[i]);

    // Reset during an APB access and a stalled AXI command aborts both silently.
    cmd_valid = 1'b1; cmd_addr = 32'h40; aready = 1'b0;
    apb_req_valid = 1'b1; apb_req_write = 1'b1; apb_req_addr = 32'h44;
    tick();
    cmd_valid = 1'b0; apb_req_valid = 1'b0;
    tick();
    check("pre_abort", {avalid, psel, penable}, 3'b111);
    rst_n = 1'b0;
    tick();
    check("abort", {avalid, psel, penable, apb_rsp_valid}, 4'b0000);
    rst_n = 1'b1; pready = 1'b1;
    tick();
    check("abort_no_rsp", {apb_rsp_valid, psel}, 2'b00);
    pready = 1'b0;

    random_phase(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sal_axi_aw_b_apb_master.md
Name: sal_axi_aw_b_apb_master

Overview:
Synthesizable bus master front-end combining three bus endpoints:
- an AXI address-channel master, used as the write-address path;
- the matching AXI write-response (B) channel slave;
- an APB master used for controller register programming.

A host-side command port replaces the bench-level init()/transfer() tasks, so the DDR controller can be driven from RTL or a sequencer. It sits between the system/test sequencer and SAL_DDR_CTRL.

Parameters:
ID_WIDTH, 4, AXI ID width.
ADDR_WIDTH, 32, AXI address width.
APB_ADDR_WIDTH, 32, APB address width.
APB_DATA_WIDTH, 32, APB data width.
MAX_OUTSTANDING, 15, maximum address handshakes awaiting a B response (1..255).

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset
cmd_valid  in  1  host AXI address command valid
cmd_ready  out  1  command accepted this cycle
cmd_id  in  ID_WIDTH  transaction ID
cmd_addr  in  ADDR_WIDTH  start address
cmd_len  in  8  beats minus one
cmd_size  in  3  bytes per beat as log2
cmd_burst  in  2  burst type (0 FIXED, 1 INCR, 2 WRAP)
avalid  out  1  AXI address valid
aready  in  1  AXI address ready
aid/aaddr/alen/asize/aburst  out  ID_WIDTH/ADDR_WIDTH/8/3/2  AXI address fields
bvalid  in  1  AXI write response valid
bready  out  1  AXI write response ready
bid  in  ID_WIDTH  response ID
bresp  in  2  response code
brsp_valid  out  1  captured B response available
brsp_ready  in  1  host pops captured B response
brsp_id  out  ID_WIDTH  captured ID
brsp_resp  out  2  captured response
outstanding  out  8  current outstanding count
apb_req_valid  in  1  host APB request
apb_req_ready  out  1  APB request accepted
apb_req_write  in  1  1 write, 0 read
apb_req_addr  in  APB_ADDR_WIDTH  register address
apb_req_wdata  in  APB_DATA_WIDTH  write data
apb_rsp_valid  out  1  one-cycle completion pulse
apb_rsp_rdata  out  APB_DATA_WIDTH  captured prdata
apb_rsp_err  out  1  captured pslverr
psel, penable, pwrite  out  1  APB control
paddr  out  APB_ADDR_WIDTH  APB address
pwdata  out  APB_DATA_WIDTH  APB write data
pready  in  1  APB ready
prdata  in  APB_DATA_WIDTH  APB read data
pslverr  in  1  APB error

Behaviour:
Reset and clocking:
- One clock, clk.
- Reset rst_n is synchronous, active-low.
- In reset, all outputs and registers are 0: avalid, address fields, bready, brsp_*, outstanding, psel, penable, pwrite, paddr, pwdata, apb_rsp_*.
- Reset mid-transaction aborts it: valid and psel drop at the next edge and no response is emitted.

Address channel:
- Single output register.
- cmd_ready = (!avalid || aready) && (outstanding < MAX_OUTSTANDING).
- On cmd_valid && cmd_ready, the fields load into the a* outputs and avalid=1 at the next edge (latency 1).
- avalid and all a* fields hold stable while avalid && !aready.
- Back-to-back commands with aready=1 issue on consecutive cycles.
- avalid clears after a handshake when no new command is accepted.
- Fields pass through unmodified; no burst legality checking.

B channel:
- bready = !brsp_valid || brsp_ready (one-entry buffer).
- On bvalid && bready, bid/bresp are captured and brsp_valid=1 next cycle.
- brsp_valid clears when popped with no new capture.

Outstanding counter:
- +1 on each address handshake (avalid && aready).
- −1 on each B handshake.
- Both in the same cycle: no change.
- A B handshake at 0 is ignored (no underflow).

APB FSM:
- States IDLE, SETUP, ACCESS.
- IDLE: apb_req_ready=1. On apb_req_valid, latch pwrite/paddr/pwdata, then go to SETUP (psel=1, penable=0).
- SETUP: always go to ACCESS (psel=1, penable=1).
- ACCESS: hold while pready=0. On pready=1, capture prdata (reads only; writes leave rdata unchanged) and pslverr, pulse apb_rsp_valid for one cycle, drop psel/penable, return to IDLE.
- Minimum transfer is 3 cycles from request to pulse.
- paddr/pwdata/pwrite hold through the transfer.
- apb_req_ready=0 outside IDLE.
- The APB path is independent of the AXI path; simultaneous activity is allowed.

Test Plan:
- Reset held 3 cycles → every output 0; after release, cmd_ready=1 and bready=1.
- Command (id 0, addr 0x0, len 0, size 0, burst 0) then (id 0, addr 0x4, ...) on consecutive cycles with aready=1 → avalid high two cycles with aaddr 0x0 then 0x4; outstanding=2.
- Same as above with aready=0 for 3 cycles → first command's fields held stable and cmd_ready=0 until aready rises.
- bvalid with bid=3, bresp=2 while brsp_ready=0 → brsp_id=3, brsp_resp=2 captured; bready=0 until popped; outstanding decrements.
- MAX_OUTSTANDING=2 with no B responses → third command stalls (cmd_ready=0); one B handshake releases it.
- APB write to 0x10 with data 0xA5A5A5A5, pready low 2 cycles → SETUP then 3 ACCESS cycles, a single apb_rsp_valid pulse. APB read with prdata=0x1234 and pslverr=1 → apb_rsp_rdata=0x1234 and apb_rsp_err=1.
